// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC-update sequencer.
//   pcs_sel_t   : PC-source mux select (3 bits, 5..7 unused)
//   pcs_kind_t  : kind of PC update requested by the main control unit
//   exc_cause_t : exception cause, also the vector-address select
//   pcs_state_t : sequencer state
//   VEC_*       : vector memory addresses selected by exc_cause_t
package pc_ctrl_pkg;

   typedef enum logic [2:0] {
      PCS_ALU_RESULT = 3'd0,   // PC+4
      PCS_ALUOUT     = 3'd1,   // branch target
      PCS_JUMP_TGT   = 3'd2,
      PCS_REG_RS     = 3'd3,   // jr
      PCS_EXC_VEC    = 3'd4
   } pcs_sel_t;

   typedef enum logic [1:0] {
      KIND_SEQ    = 2'd0,
      KIND_BRANCH = 2'd1,
      KIND_JUMP   = 2'd2,
      KIND_JR     = 2'd3
   } pcs_kind_t;

   typedef enum logic [1:0] {
      CAUSE_NONE   = 2'd0,
      CAUSE_OPCODE = 2'd1,
      CAUSE_OVF    = 2'd2,
      CAUSE_DIV0   = 2'd3
   } exc_cause_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXC_SAVE = 2'd1,
      ST_EXC_WAIT = 2'd2,
      ST_EXC_LOAD = 2'd3
   } pcs_state_t;

   localparam logic [7:0] VEC_OPCODE = 8'hFD;
   localparam logic [7:0] VEC_OVF    = 8'hFE;
   localparam logic [7:0] VEC_DIV0   = 8'hFF;

   // Vector address for a cause; NONE maps to 0 (no vector fetched).
   function automatic logic [7:0] cause_to_vec(input exc_cause_t cause);
      logic [7:0] addr;
      case (cause)
         CAUSE_OPCODE: addr = VEC_OPCODE;
         CAUSE_OVF:    addr = VEC_OVF;
         CAUSE_DIV0:   addr = VEC_DIV0;
         default:      addr = 8'h00;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder for the three exception flags.
// Priority: invalid opcode > overflow > divide-by-zero.
//   exc_opcode, exc_ovf, exc_div0 : exception flags (inputs)
//   cause                         : highest-priority cause, NONE if no flag
//   any_exc                       : at least one flag set
module exc_prio_enc
   import pc_ctrl_pkg::*;
(
   input  logic       exc_opcode,
   input  logic       exc_ovf,
   input  logic       exc_div0,
   output exc_cause_t cause,
   output logic       any_exc
);

   always_comb begin
      cause = CAUSE_NONE;
      if (exc_opcode) begin
         cause = CAUSE_OPCODE;
      end else if (exc_ovf) begin
         cause = CAUSE_OVF;
      end else if (exc_div0) begin
         cause = CAUSE_DIV0;
      end
   end

   assign any_exc = exc_opcode | exc_ovf | exc_div0;

endmodule

// File: rtl/pc_source_ctrl.sv
// PC-update sequencer for the multicycle CPU.
// Accepts one PC-update request per instruction, resolves
// exception > jump/jr > branch > sequential, and drives the PC-source
// select, PC write and EPC write. Exceptions run a vector fetch:
// save EPC + read vector, wait MEM_LAT-1 cycles, load PC from vector.
// Ports:
//   clk, reset (async, active low)
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_kind, br_ne, zero, exc_* : request contents, sampled at acceptance
//   pc_source, pc_write, epc_write, vec_rd, vec_sel, done : registered outputs
module pc_source_ctrl
   import pc_ctrl_pkg::*;
#(
   parameter int MEM_LAT = 2   // vec_rd to valid vector data, 1..15
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [1:0] req_kind,
   input  logic       br_ne,
   input  logic       zero,
   input  logic       exc_opcode,
   input  logic       exc_ovf,
   input  logic       exc_div0,
   output logic [2:0] pc_source,
   output logic       pc_write,
   output logic       epc_write,
   output logic       vec_rd,
   output logic [1:0] vec_sel,
   output logic       done
);

   localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

   pcs_state_t state_reg;
   logic [3:0] cnt_reg;
   pcs_kind_t  kind;
   exc_cause_t cause;
   logic       any_exc;

   assign kind = pcs_kind_t'(req_kind);

   exc_prio_enc u_prio (
      .exc_opcode (exc_opcode),
      .exc_ovf    (exc_ovf),
      .exc_div0   (exc_div0),
      .cause      (cause),
      .any_exc    (any_exc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= 4'd0;
         req_ready <= 1'b1;
         pc_source <= PCS_ALU_RESULT;
         pc_write  <= 1'b0;
         epc_write <= 1'b0;
         vec_rd    <= 1'b0;
         vec_sel   <= CAUSE_NONE;
         done      <= 1'b0;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         pc_write  <= 1'b0;
         epc_write <= 1'b0;
         vec_rd    <= 1'b0;
         done      <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               vec_sel   <= CAUSE_NONE;
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  if (any_exc) begin
                     // req_kind is irrelevant once an exception is flagged.
                     state_reg <= ST_EXC_SAVE;
                     req_ready <= 1'b0;
                     epc_write <= 1'b1;
                     vec_rd    <= 1'b1;
                     vec_sel   <= cause;
                  end else begin
                     done <= 1'b1;
                     case (kind)
                        KIND_SEQ: begin
                           pc_source <= PCS_ALU_RESULT;
                           pc_write  <= 1'b1;
                        end
                        KIND_BRANCH: begin
                           // beq taken on zero, bne taken on !zero.
                           pc_source <= PCS_ALUOUT;
                           pc_write  <= zero ^ br_ne;
                        end
                        KIND_JUMP: begin
                           pc_source <= PCS_JUMP_TGT;
                           pc_write  <= 1'b1;
                        end
                        default: begin
                           pc_source <= PCS_REG_RS;
                           pc_write  <= 1'b1;
                        end
                     endcase
                  end
               end
            end

            ST_EXC_SAVE: begin
               cnt_reg <= LAT_M1;
               if (MEM_LAT == 1) begin
                  // Vector already valid next cycle: skip the wait state.
                  state_reg <= ST_EXC_LOAD;
                  pc_source <= PCS_EXC_VEC;
                  pc_write  <= 1'b1;
                  done      <= 1'b1;
               end else begin
                  state_reg <= ST_EXC_WAIT;
               end
            end

            ST_EXC_WAIT: begin
               cnt_reg <= cnt_reg - 4'd1;
               // Counter reaches zero on this edge: the load outputs must be
               // registered now so they appear in the EXC_LOAD cycle.
               if (cnt_reg <= 4'd1) begin
                  state_reg <= ST_EXC_LOAD;
                  pc_source <= PCS_EXC_VEC;
                  pc_write  <= 1'b1;
                  done      <= 1'b1;
               end
            end

            ST_EXC_LOAD: begin
               state_reg <= ST_IDLE;
               vec_sel   <= CAUSE_NONE;
               req_ready <= 1'b1;
            end

            default: begin
               state_reg <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_source_ctrl.sv
// Directed testbench for pc_source_ctrl: instance A uses MEM_LAT=2,
// instance B uses MEM_LAT=1. Inputs are driven 1ns after the rising edge
// and outputs sampled there, i.e. they show the cycle after that edge.
module tb_pc_source_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid, req_valid_b;
   logic [1:0] req_kind;
   logic       br_ne, zero, exc_opcode, exc_ovf, exc_div0;

   logic       req_ready, pc_write, epc_write, vec_rd, done;
   logic [2:0] pc_source;
   logic [1:0] vec_sel;
   logic       req_ready_b, pc_write_b, epc_write_b, vec_rd_b, done_b;
   logic [2:0] pc_source_b;
   logic [1:0] vec_sel_b;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_source_ctrl #(.MEM_LAT(2)) dut_a (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_kind(req_kind), .br_ne(br_ne), .zero(zero),
      .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
      .pc_source(pc_source), .pc_write(pc_write), .epc_write(epc_write),
      .vec_rd(vec_rd), .vec_sel(vec_sel), .done(done)
   );

   pc_source_ctrl #(.MEM_LAT(1)) dut_b (
      .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_kind(req_kind), .br_ne(br_ne), .zero(zero),
      .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
      .pc_source(pc_source_b), .pc_write(pc_write_b), .epc_write(epc_write_b),
      .vec_rd(vec_rd_b), .vec_sel(vec_sel_b), .done(done_b)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_valid_b = 1'b0; req_kind = 2'd0;
      br_ne = 1'b0; zero = 1'b0;
      exc_opcode = 1'b0; exc_ovf = 1'b0; exc_div0 = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      step(); step();
      checks++; if (pc_source !== 3'd0) begin failures++; $display("FAIL reset_pc_source got=%0d exp=0", pc_source); end
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL reset_pc_write got=%0b exp=0", pc_write); end
      checks++; if (epc_write !== 1'b0) begin failures++; $display("FAIL reset_epc_write got=%0b exp=0", epc_write); end
      checks++; if (vec_rd !== 1'b0) begin failures++; $display("FAIL reset_vec_rd got=%0b exp=0", vec_rd); end
      checks++; if (vec_sel !== 2'd0) begin failures++; $display("FAIL reset_vec_sel got=%0d exp=0", vec_sel); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
      reset = 1'b1;
      step(); step();
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%0b exp=1", req_ready); end
      $display("reset: released, req_ready=%0b", req_ready);
   endtask

   task automatic test_seq();
      req_valid = 1'b1; req_kind = 2'd0;
      step();
      checks++; if (pc_source !== 3'd0) begin failures++; $display("FAIL seq_pc_source got=%0d exp=0", pc_source); end
      checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL seq_pc_write got=%0b exp=1", pc_write); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL seq_done got=%0b exp=1", done); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL seq_req_ready got=%0b exp=1", req_ready); end
      req_valid = 1'b0;
      step();
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL seq_pc_write_off got=%0b exp=0", pc_write); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL seq_done_off got=%0b exp=0", done); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL seq_req_ready_after got=%0b exp=1", req_ready); end
      $display("seq: pc_source=%0d", pc_source);
   endtask

   // Back-to-back requests, one per cycle: {kind, br_ne, zero} -> {pc_source, pc_write}
   task automatic test_back_to_back();
      logic [1:0] kind_tab [6];
      logic       brne_tab [6];
      logic       zero_tab [6];
      logic [2:0] exp_src  [6];
      logic       exp_pw   [6];
      kind_tab = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      brne_tab = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      zero_tab = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_src  = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
      exp_pw   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         req_valid = 1'b1; req_kind = kind_tab[i]; br_ne = brne_tab[i]; zero = zero_tab[i];
         step();
         checks++; if (pc_source !== exp_src[i]) begin failures++; $display("FAIL b2b_pc_source[%0d] got=%0d exp=%0d", i, pc_source, exp_src[i]); end
         checks++; if (pc_write !== exp_pw[i]) begin failures++; $display("FAIL b2b_pc_write[%0d] got=%0b exp=%0b", i, pc_write, exp_pw[i]); end
         checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done[%0d] got=%0b exp=1", i, done); end
         $display("b2b[%0d]: kind=%0d br_ne=%0b zero=%0b -> pc_source=%0d pc_write=%0b", i, kind_tab[i], brne_tab[i], zero_tab[i], pc_source, pc_write);
      end
      req_valid = 1'b0; br_ne = 1'b0; zero = 1'b0;
      step();
      checks++; if (pc_source !== 3'd1) begin failures++; $display("FAIL b2b_pc_source_hold got=%0d exp=1", pc_source); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done_off got=%0b exp=0", done); end
   endtask

   task automatic test_exception();
      req_valid = 1'b1; req_kind = 2'd2; exc_ovf = 1'b1;
      step();   // T+1
      req_valid = 1'b0; exc_ovf = 1'b0;
      checks++; if (epc_write !== 1'b1) begin failures++; $display("FAIL exc_t1_epc_write got=%0b exp=1", epc_write); end
      checks++; if (vec_rd !== 1'b1) begin failures++; $display("FAIL exc_t1_vec_rd got=%0b exp=1", vec_rd); end
      checks++; if (vec_sel !== 2'd2) begin failures++; $display("FAIL exc_t1_vec_sel got=%0d exp=2", vec_sel); end
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL exc_t1_pc_write got=%0b exp=0", pc_write); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL exc_t1_req_ready got=%0b exp=0", req_ready); end
      step();   // T+2
      checks++; if (epc_write !== 1'b0) begin failures++; $display("FAIL exc_t2_epc_write got=%0b exp=0", epc_write); end
      checks++; if (vec_rd !== 1'b0) begin failures++; $display("FAIL exc_t2_vec_rd got=%0b exp=0", vec_rd); end
      checks++; if (vec_sel !== 2'd2) begin failures++; $display("FAIL exc_t2_vec_sel got=%0d exp=2", vec_sel); end
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL exc_t2_pc_write got=%0b exp=0", pc_write); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL exc_t2_req_ready got=%0b exp=0", req_ready); end
      step();   // T+3
      checks++; if (pc_source !== 3'd4) begin failures++; $display("FAIL exc_t3_pc_source got=%0d exp=4", pc_source); end
      checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL exc_t3_pc_write got=%0b exp=1", pc_write); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL exc_t3_done got=%0b exp=1", done); end
      checks++; if (vec_sel !== 2'd2) begin failures++; $display("FAIL exc_t3_vec_sel got=%0d exp=2", vec_sel); end
      checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL exc_t3_req_ready got=%0b exp=0", req_ready); end
      step();   // T+4, back in IDLE
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL exc_t4_pc_write got=%0b exp=0", pc_write); end
      checks++; if (vec_sel !== 2'd0) begin failures++; $display("FAIL exc_t4_vec_sel got=%0d exp=0", vec_sel); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL exc_t4_req_ready got=%0b exp=1", req_ready); end
      $display("exception ovf: pc_source=%0d req_ready=%0b", pc_source, req_ready);
   endtask

   // Flags {opcode, ovf, div0} -> expected vec_sel.
   task automatic test_priority();
      logic [2:0] flag_tab [4];
      logic [1:0] exp_sel  [4];
      flag_tab = '{3'b111, 3'b011, 3'b001, 3'b110};
      exp_sel  = '{2'd1, 2'd2, 2'd3, 2'd1};
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_kind = 2'd0;
         {exc_opcode, exc_ovf, exc_div0} = flag_tab[i];
         step();
         req_valid = 1'b0; {exc_opcode, exc_ovf, exc_div0} = 3'b000;
         checks++; if (vec_sel !== exp_sel[i]) begin failures++; $display("FAIL prio_vec_sel[%0d] got=%0d exp=%0d", i, vec_sel, exp_sel[i]); end
         step(); step();
         checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL prio_pc_write[%0d] got=%0b exp=1", i, pc_write); end
         $display("prio[%0d]: flags=%03b vec_sel=%0d", i, flag_tab[i], exp_sel[i]);
         step();
      end
   endtask

   task automatic test_mem_lat1();
      req_valid_b = 1'b1; req_kind = 2'd0;
      {exc_opcode, exc_ovf, exc_div0} = 3'b111;
      step();   // T+1
      req_valid_b = 1'b0; {exc_opcode, exc_ovf, exc_div0} = 3'b000;
      checks++; if (vec_sel_b !== 2'd1) begin failures++; $display("FAIL lat1_vec_sel got=%0d exp=1", vec_sel_b); end
      checks++; if (epc_write_b !== 1'b1) begin failures++; $display("FAIL lat1_epc_write got=%0b exp=1", epc_write_b); end
      checks++; if (pc_write_b !== 1'b0) begin failures++; $display("FAIL lat1_t1_pc_write got=%0b exp=0", pc_write_b); end
      checks++; if (req_ready_b !== 1'b0) begin failures++; $display("FAIL lat1_t1_req_ready got=%0b exp=0", req_ready_b); end
      step();   // T+2
      checks++; if (pc_write_b !== 1'b1) begin failures++; $display("FAIL lat1_t2_pc_write got=%0b exp=1", pc_write_b); end
      checks++; if (pc_source_b !== 3'd4) begin failures++; $display("FAIL lat1_t2_pc_source got=%0d exp=4", pc_source_b); end
      checks++; if (done_b !== 1'b1) begin failures++; $display("FAIL lat1_t2_done got=%0b exp=1", done_b); end
      checks++; if (epc_write_b !== 1'b0) begin failures++; $display("FAIL lat1_t2_epc_write got=%0b exp=0", epc_write_b); end
      step();   // T+3
      checks++; if (pc_write_b !== 1'b0) begin failures++; $display("FAIL lat1_t3_pc_write got=%0b exp=0", pc_write_b); end
      checks++; if (req_ready_b !== 1'b1) begin failures++; $display("FAIL lat1_t3_req_ready got=%0b exp=1", req_ready_b); end
      $display("mem_lat1: exception completed, pc_source=%0d", pc_source_b);
   endtask

   task automatic test_reset_mid();
      int n_pw;
      req_valid = 1'b1; req_kind = 2'd0; exc_div0 = 1'b1;
      step();   // T+1 EXC_SAVE
      req_valid = 1'b0; exc_div0 = 1'b0;
      step();   // T+2 EXC_WAIT
      checks++; if (vec_sel !== 2'd3) begin failures++; $display("FAIL rmid_pre_vec_sel got=%0d exp=3", vec_sel); end
      #2 reset = 1'b0;
      #1;
      checks++; if (vec_sel !== 2'd0) begin failures++; $display("FAIL rmid_vec_sel got=%0d exp=0", vec_sel); end
      checks++; if (pc_source !== 3'd0) begin failures++; $display("FAIL rmid_pc_source got=%0d exp=0", pc_source); end
      checks++; if (pc_write !== 1'b0) begin failures++; $display("FAIL rmid_pc_write got=%0b exp=0", pc_write); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rmid_req_ready got=%0b exp=1", req_ready); end
      step();
      reset = 1'b1;
      n_pw = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (pc_write === 1'b1) n_pw++;
      end
      checks++; if (n_pw !== 0) begin failures++; $display("FAIL rmid_no_pc_write got=%0d exp=0", n_pw); end
      req_valid = 1'b1; req_kind = 2'd3;
      step();
      req_valid = 1'b0;
      checks++; if (pc_source !== 3'd3) begin failures++; $display("FAIL rmid_jr_pc_source got=%0d exp=3", pc_source); end
      checks++; if (pc_write !== 1'b1) begin failures++; $display("FAIL rmid_jr_pc_write got=%0b exp=1", pc_write); end
      step();
      $display("reset_mid: aborted sequence, jr after release pc_source=3");
   endtask

   task automatic test_ignore_during_wait();
      int n_pw;
      int n_done;
      req_valid = 1'b1; req_kind = 2'd0; exc_ovf = 1'b1;
      step();   // T+1
      exc_ovf = 1'b0;   // req_valid stays high through the busy cycles
      n_pw = 0; n_done = 0;
      for (int i = 0; i < 6; i++) begin
         if (pc_write === 1'b1) n_pw++;
         if (done === 1'b1) n_done++;
         if (i == 2) req_valid = 1'b0;   // drop before IDLE would accept it
         step();
      end
      checks++; if (n_done !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", n_done); end
      checks++; if (n_pw !== 1) begin failures++; $display("FAIL ignore_pc_write_count got=%0d exp=1", n_pw); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL ignore_req_ready got=%0b exp=1", req_ready); end
      $display("ignore_during_wait: done pulses=%0d pc_write pulses=%0d", n_done, n_pw);
   endtask

   initial begin
      test_reset();
      test_seq();
      test_back_to_back();
      test_exception();
      test_priority();
      test_mem_lat1();
      test_reset_mid();
      test_ignore_during_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_source_ctrl.md
Name: pc_source_ctrl

Overview:
Sequencer for the multicycle CPU's PC-update path. It takes one PC-update request per instruction from the main control unit, resolves the request priority (exception > jump > branch > sequential) and drives the PC-source select, PC write enable and EPC write. For exceptions it runs the multi-cycle vector fetch: save EPC, wait for the vector memory read, then load the PC from the vector.

Parameters:
MEM_LAT, 2, cycles from vec_rd assertion to valid vector data at the PC-source input; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  main control presents a PC-update request
req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready
req_kind  input  2  pcs_kind_t: SEQ=0, BRANCH=1, JUMP=2, JR=3
br_ne  input  1  branch sense: 0 = beq (taken when zero=1), 1 = bne (taken when zero=0)
zero  input  1  ALU zero flag, sampled at acceptance
exc_opcode  input  1  invalid-opcode exception, sampled at acceptance
exc_ovf  input  1  arithmetic-overflow exception, sampled at acceptance
exc_div0  input  1  divide-by-zero exception, sampled at acceptance
pc_source  output  3  PC-source select (pcs_sel_t)
pc_write  output  1  one-cycle PC load enable
epc_write  output  1  one-cycle EPC load enable
vec_rd  output  1  vector memory read strobe
vec_sel  output  2  exc_cause_t: selects vector address 0xFD/0xFE/0xFF
done  output  1  one-cycle pulse when the request completes

Behaviour:
- All outputs are registered. Reset (asynchronous, any state): state=IDLE, pc_source=0, pc_write=0, epc_write=0, vec_rd=0, vec_sel=0, done=0, counter=0. req_ready=1 after reset releases.
- pcs_sel_t encodings:
  - ALU_RESULT=0 (PC+4)
  - ALUOUT=1 (branch target)
  - JUMP_TGT=2
  - REG_RS=3 (jr)
  - EXC_VEC=4
  - 5..7 are never driven.
- States: IDLE, EXC_SAVE, EXC_WAIT, EXC_LOAD.
- IDLE, request accepted at edge T:
  - Any exception flag set: go to EXC_SAVE. Cause priority: opcode (vec_sel=1, 0xFD) > ovf (vec_sel=2, 0xFE) > div0 (vec_sel=3, 0xFF). req_kind is ignored.
  - No exception, SEQ: cycle T+1 drives pc_source=ALU_RESULT, pc_write=1, done=1.
  - No exception, JUMP: cycle T+1 drives pc_source=JUMP_TGT, pc_write=1, done=1.
  - No exception, JR: cycle T+1 drives pc_source=REG_RS, pc_write=1, done=1.
  - No exception, BRANCH: taken = zero XOR br_ne. Cycle T+1 drives pc_source=ALUOUT, pc_write=taken, done=1. Not-taken still pulses done.
  - The controller stays in IDLE for all non-exception requests, so back-to-back requests are accepted every cycle.
- EXC_SAVE (cycle T+1): epc_write=1, vec_rd=1, vec_sel=cause, pc_write=0. Load counter=MEM_LAT-1, then go to EXC_WAIT (or to EXC_LOAD if MEM_LAT=1).
- EXC_WAIT: vec_rd=0; vec_sel holds its value. Decrement the counter; go to EXC_LOAD when the counter reaches 0.
- EXC_LOAD (cycle T+1+MEM_LAT): pc_source=EXC_VEC, pc_write=1, done=1. Next state is IDLE.
- Exception total latency: acceptance to pc_write = MEM_LAT+1 cycles.
- req_ready=0 in all EXC_* states. Requests and exception flags presented then are ignored; they are not queued.
- pc_write, epc_write, vec_rd and done are single-cycle pulses and are never high for two consecutive cycles within one exception sequence.
- vec_sel is held constant from EXC_SAVE through EXC_LOAD and returns to 0 in IDLE.
- pc_source holds its last driven value when pc_write=0.
- Reset asserted mid-sequence aborts the sequence immediately: no pc_write is issued for the aborted request.

Decomposition:
- Package pc_ctrl_pkg holds: pcs_sel_t (3-bit enum), pcs_kind_t (2-bit enum), exc_cause_t (2-bit enum, NONE=0), the state enum, and vector address constants VEC_OPCODE=8'hFD, VEC_OVF=8'hFE, VEC_DIV0=8'hFF.
- One sub-module, exc_prio_enc: combinational priority encoder from the three exception flags to exc_cause_t plus an any_exc bit.
- FSM and counter stay in pc_source_ctrl.

Test Plan:
- Reset release, then SEQ request at cycle 5 -> cycle 6: pc_source=0, pc_write=1, done=1; cycle 7: pc_write=0; req_ready=1 throughout.
- BRANCH with br_ne=0, zero=1, then BRANCH with br_ne=1, zero=1 back-to-back -> first pc_write=1, pc_source=1; second pc_write=0, done=1 both cycles.
- MEM_LAT=2, exc_ovf=1 with req_kind=JUMP -> T+1: epc_write=1, vec_rd=1, vec_sel=2; T+2: wait; T+3: pc_source=4, pc_write=1, done=1; req_ready low T+1..T+3.
- exc_opcode=1, exc_ovf=1, exc_div0=1 together -> vec_sel=1. Repeat with MEM_LAT=1: pc_write at T+2.
- Reset asserted during EXC_WAIT -> outputs 0 asynchronously, no pc_write afterwards. New JR request after release -> pc_source=3, pc_write=1.
- Request with req_valid=1 during EXC_WAIT -> ignored: exactly one done pulse for the exception sequence, no extra pc_write.
